modex_decrypt_sequencer: RTL

//  Sequences the modular-exponentiation decrypt datapath over a block of the encrypted-word memory.
//  For each word it:
//   - drives the memory address
//   - restarts the Mod_Exp core via its reset input
//   - waits for finish
//   - emits the decrypted word on a valid/ready stream.

---
 rtl/modex_decrypt_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/modex_decrypt_sequencer.sv
// Sequences one Mod_Exp decrypt per word across a block of encrypted memory.
// Each word result goes out on a valid/ready stream; a per-word timeout aborts the job.
module modex_decrypt_sequencer #(
    parameter int ARQ       = 16,
    parameter int ADDR      = 17,
    parameter int TIMEOUT_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [ADDR-1:0] i_base_addr,
    input  logic [ADDR-1:0] i_word_count,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err_timeout,
    output logic [ADDR-1:0] o_mem_addr,
    output logic            o_mex_rst,
    input  logic            i_mex_finish,
    input  logic [ARQ-1:0]  i_mex_result,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [ARQ-1:0]  o_out_data,
    output logic [ADDR-1:0] o_out_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_KICK,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [ADDR-1:0]      ADDR_ONE = ADDR'(1);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR-1:0]       r_addr;
    logic [ADDR-1:0]       r_rem;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic [ARQ-1:0]        r_out_data;
    logic [ADDR-1:0]       r_out_addr;
    logic                  r_err;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_xfer;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_xfer      = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mex_rst   = 1'b1;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = (i_word_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                o_busy = 1'b1;
                w_next = S_KICK;
            end
            S_KICK: begin
                o_busy = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // finish is only trusted here; a stale flag during KICK is ignored
                o_busy    = 1'b1;
                o_mex_rst = 1'b0;
                if (i_mex_finish) begin
                    w_capture = 1'b1;
                    w_next    = S_EMIT;
                end else if (r_tmo == TMO_ONE) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_EMIT: begin
                o_busy      = 1'b1;
                o_mex_rst   = 1'b0;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_xfer = 1'b1;
                    w_next = (r_rem == ADDR_ONE) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Timeout is a down-counter loaded in KICK; reaching one in WAIT means
    // 2**TIMEOUT_W-1 cycles elapsed without finish.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_rem      <= '0;
            r_tmo      <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr <= i_base_addr;
                r_rem  <= i_word_count;
                r_err  <= 1'b0;
            end
            if (r_state == S_KICK) begin
                r_tmo <= '1;
            end else if (r_state == S_WAIT) begin
                r_tmo <= r_tmo - TMO_ONE;
            end
            if (w_capture) begin
                r_out_data <= i_mex_result;
                r_out_addr <= r_addr;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_xfer) begin
                r_addr <= r_addr + ADDR_ONE;
                r_rem  <= r_rem - ADDR_ONE;
            end
        end
    end

    assign o_mem_addr    = r_addr;
    assign o_err_timeout = r_err;
    assign o_out_data    = r_out_data;
    assign o_out_addr    = r_out_addr;

endmodule
